test_timer_core: RTL and testbench

- Programmable periodic match timer.
- A free-running up-counter is compared every cycle against a run-time match value. On equality the counter restarts from zero and a one-cycle match pulse is issued.
- Used as a periodic tick/event generator for downstream control logic. Period = MATCH_IN + 1 clock cycles.

---
 rtl/test_timer_core_pkg.sv | 8 +
 rtl/test_timer_core_counter.sv | 26 ++
 rtl/test_timer_core.sv | 37 +++
 tb/tb_test_timer_core.sv | 138 +++++++++++++
 4 files changed

// File: rtl/test_timer_core_pkg.sv
// Shared definitions for the periodic match timer.
package test_timer_core_pkg;

  localparam int unsigned TIMER_WIDTH_DEFAULT = 5;

  typedef logic [TIMER_WIDTH_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/test_timer_core_counter.sv
// Free-running up-counter with a synchronous return-to-zero.
module timer_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Overflow wraps naturally; only i_clr restarts the period early.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/test_timer_core.sv
// Periodic match timer: pulses MATCH_OUT once every MATCH_IN+1 cycles.
module test_timer_core
  import test_timer_core_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] MATCH_IN,
  output logic             MATCH_OUT
);

  logic [WIDTH-1:0] w_cnt;
  logic             w_hit;
  logic             r_match_out;

  assign w_hit = (w_cnt == MATCH_IN);

  timer_counter #(.WIDTH(WIDTH)) u_counter (
    .CLK   (CLK),
    .RST   (RST),
    .i_clr (w_hit),
    .o_cnt (w_cnt)
  );

  // Registered so MATCH_IN never reaches the output combinationally.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_match_out <= '0;
    end else begin
      r_match_out <= w_hit;
    end
  end

  assign MATCH_OUT = r_match_out;

endmodule

// File: tb/tb_test_timer_core.sv
// Self-checking bench for test_timer_core against a behavioural timer model.
module tb_test_timer_core;

  localparam int unsigned W   = 5;
  localparam int          MOD = 1 << W;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] MATCH_IN = 5'd20;
  logic         MATCH_OUT;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt = 0;
  bit m_out = 1'b0;

  test_timer_core #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MATCH_IN  (MATCH_IN),
    .MATCH_OUT (MATCH_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance the model from the rules, then compare 1 time unit later.
  task automatic step();
    @(posedge CLK);
    if (RST) begin
      if (m_cnt == int'(MATCH_IN)) begin
        m_cnt = 0;
        m_out = 1'b1;
      end else begin
        m_cnt = (m_cnt + 1) % MOD;
        m_out = 1'b0;
      end
    end
    #1;
    check("match_out", {31'd0, MATCH_OUT}, {31'd0, m_out});
    check("cnt", {27'd0, dut.w_cnt}, m_cnt);
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    #1;
    m_cnt = 0;
    m_out = 1'b0;
    check("rst_async_out", {31'd0, MATCH_OUT}, 0);
    check("rst_async_cnt", {27'd0, dut.w_cnt}, 0);
    repeat (3) step();
    RST = 1'b1;
  endtask

  task automatic next_pulse(input int budget, output int edges);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (MATCH_OUT) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int e;
    #2;
    apply_reset();

    // Nominal period of 21 from release.
    next_pulse(30, e); check("nom_first", e, 21);
    for (int k = 0; k < 3; k++) begin
      next_pulse(30, e); check("nom_period", e, 21);
    end

    // Zero match: high every cycle.
    MATCH_IN = 5'd0;
    #3 apply_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      check("zero_high", {31'd0, MATCH_OUT}, 1);
    end

    // Asynchronous clear while the output is high, mid-cycle.
    #3 apply_reset();

    // Max match: period 32, no extra pulse on wrap.
    MATCH_IN = 5'd31;
    next_pulse(40, e); check("max_first", e, 32);
    next_pulse(40, e); check("max_period", e, 32);

    // Dynamic lowering: count 10..31, wrap, 0..5, match on the 28th edge.
    MATCH_IN = 5'd20;
    #3 apply_reset();
    repeat (10) step();
    check("dyn_cnt10", {27'd0, dut.w_cnt}, 10);
    MATCH_IN = 5'd5;
    next_pulse(40, e); check("dyn_wrap", e, 28);
    next_pulse(40, e); check("dyn_period", e, 6);

    // Reset mid-count restarts the full period.
    MATCH_IN = 5'd20;
    #3 apply_reset();
    repeat (15) step();
    #3 apply_reset();
    next_pulse(30, e); check("midrst_first", e, 21);

    // Randomized MATCH_IN changes and occasional resets.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        MATCH_IN = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      end
      if ($urandom_range(0, 149) == 0) begin
        #($urandom_range(1, 3)) apply_reset();
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
